operand_writeback: RTL and testbench

- Producer end of the operand-forwarding interface: final pipeline stage that retires results into R0, the RN register file, data memory or IO.
- Drives the forwarded value and load strobes (OF_OD1, L_R0, LRN, FLRN, OpcodeWB) consumed by the stage-1 operand decoders.
- Owns the architectural R0 and RN registers, including their read ports.
- Runs a handshaked write FSM with a watchdog for memory/IO stores.

---
 rtl/operand_writeback.sv | 162 ++++++++++++++++
 tb/tb_operand_writeback.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_writeback.sv
// operand_writeback: last pipeline stage. Retires results into R0, the RN
// register file, data memory or IO. Forwards the retiring value to the
// stage-1 operand decoders in the same cycle it is accepted.
`timescale 1ns/1ps
module operand_writeback #(
   parameter int DATA_W      = 16,
   parameter int RN_COUNT    = 8,
   parameter int OPC_W       = 3,
   parameter int ACK_TIMEOUT = 15,
   localparam int IDX_W      = $clog2(RN_COUNT)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [OPC_W-1:0]  wb_opcode,
   input  logic [1:0]        wb_dest,
   input  logic [IDX_W-1:0]  wb_rn_idx,
   input  logic              wb_io,
   input  logic [DATA_W-1:0] wb_addr,
   output logic              mem_wr_req,
   output logic [DATA_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic              mem_wr_ack,
   output logic              io_wr_req,
   output logic [DATA_W-1:0] io_wr_data,
   input  logic              io_wr_ack,
   input  logic [IDX_W-1:0]  rn_sel,
   output logic [DATA_W-1:0] RN_Out,
   output logic [DATA_W-1:0] R0_Out,
   output logic [DATA_W-1:0] OF_OD1,
   output logic              L_R0,
   output logic              LRN,
   output logic              FLRN,
   output logic [OPC_W-1:0]  OpcodeWB,
   output logic              err_sticky,
   input  logic              err_clr
);

   localparam logic [1:0] DEST_R0    = 2'b01;
   localparam logic [1:0] DEST_RN    = 2'b10;
   localparam logic [1:0] DEST_STORE = 2'b11;

   // Last wait cycle index: the counter starts at 0 in the first wait cycle,
   // so a store that sees no ack in this cycle has waited ACK_TIMEOUT cycles.
   localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      MEM_WAIT,
      IO_WAIT
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              accept;
   logic              store_accept;
   logic              timeout;
   logic [7:0]        wait_cnt;
   logic [DATA_W-1:0] rn_reg [RN_COUNT];
   logic [DATA_W-1:0] r0_reg;

   assign accept       = wb_valid && (state == IDLE);
   assign store_accept = accept && (wb_dest == DEST_STORE);

   // Same-cycle forwarding to the operand decoders
   assign OF_OD1 = accept ? wb_data : '0;
   assign L_R0   = accept && (wb_dest == DEST_R0);
   assign LRN    = accept && (wb_dest == DEST_RN);
   assign FLRN   = LRN && (wb_rn_idx == rn_sel);
   assign RN_Out = rn_reg[rn_sel];
   assign R0_Out = r0_reg;

   // Store FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Store FSM next state, handshake outputs and timeout detection
   always_comb begin
      state_next = state;
      wb_ready   = 1'b0;
      mem_wr_req = 1'b0;
      io_wr_req  = 1'b0;
      timeout    = 1'b0;
      case (state)
         IDLE: begin
            wb_ready = 1'b1;
            if (store_accept) state_next = wb_io ? IO_WAIT : MEM_WAIT;
         end
         MEM_WAIT: begin
            mem_wr_req = 1'b1;
            if (mem_wr_ack) begin
               state_next = IDLE;
            end else if (wait_cnt == LAST_WAIT) begin
               state_next = IDLE;
               timeout    = 1'b1;
            end
         end
         IO_WAIT: begin
            io_wr_req = 1'b1;
            if (io_wr_ack) begin
               state_next = IDLE;
            end else if (wait_cnt == LAST_WAIT) begin
               state_next = IDLE;
               timeout    = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Wait-cycle counter, restarted by every store accept
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)              wait_cnt <= '0;
      else if (store_accept)     wait_cnt <= '0;
      else if (state != IDLE)    wait_cnt <= wait_cnt + 8'd1;
   end

   // Store address/data capture; held stable for the whole wait
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
         io_wr_data  <= '0;
      end else if (store_accept) begin
         if (wb_io) begin
            io_wr_data  <= wb_data;
         end else begin
            mem_wr_addr <= wb_addr;
            mem_wr_data <= wb_data;
         end
      end
   end

   // Architectural R0 and RN register updates
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r0_reg <= '0;
         for (int i = 0; i < RN_COUNT; i++) rn_reg[i] <= '0;
      end else if (accept) begin
         if (wb_dest == DEST_R0) r0_reg <= wb_data;
         if (wb_dest == DEST_RN) rn_reg[wb_rn_idx] <= wb_data;
      end
   end

   // Opcode of the last accepted result
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    OpcodeWB <= '0;
      else if (accept) OpcodeWB <= wb_opcode;
   end

   // Sticky store-timeout flag; a new timeout beats a clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     err_sticky <= 1'b0;
      else if (timeout) err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;
   end

endmodule

// File: tb/tb_operand_writeback.sv
// Bench for operand_writeback: directed vectors with literal expectations,
// plus a transaction-level model checked against the DUT on every negedge.
`timescale 1ns/1ps
module tb_operand_writeback;

   localparam int DATA_W      = 16;
   localparam int RN_COUNT    = 8;
   localparam int OPC_W       = 3;
   localparam int ACK_TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              wb_valid = 1'b0;
   logic              wb_ready;
   logic [DATA_W-1:0] wb_data = '0;
   logic [OPC_W-1:0]  wb_opcode = '0;
   logic [1:0]        wb_dest = '0;
   logic [2:0]        wb_rn_idx = '0;
   logic              wb_io = 1'b0;
   logic [DATA_W-1:0] wb_addr = '0;
   logic              mem_wr_req;
   logic [DATA_W-1:0] mem_wr_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic              mem_wr_ack = 1'b0;
   logic              io_wr_req;
   logic [DATA_W-1:0] io_wr_data;
   logic              io_wr_ack = 1'b0;
   logic [2:0]        rn_sel = '0;
   logic [DATA_W-1:0] RN_Out;
   logic [DATA_W-1:0] R0_Out;
   logic [DATA_W-1:0] OF_OD1;
   logic              L_R0;
   logic              LRN;
   logic              FLRN;
   logic [OPC_W-1:0]  OpcodeWB;
   logic              err_sticky;
   logic              err_clr = 1'b0;

   always #5 clk = ~clk;

   operand_writeback #(
      .DATA_W(DATA_W), .RN_COUNT(RN_COUNT), .OPC_W(OPC_W), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
      .wb_opcode(wb_opcode), .wb_dest(wb_dest), .wb_rn_idx(wb_rn_idx),
      .wb_io(wb_io), .wb_addr(wb_addr),
      .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_wr_ack(mem_wr_ack),
      .io_wr_req(io_wr_req), .io_wr_data(io_wr_data), .io_wr_ack(io_wr_ack),
      .rn_sel(rn_sel), .RN_Out(RN_Out), .R0_Out(R0_Out), .OF_OD1(OF_OD1),
      .L_R0(L_R0), .LRN(LRN), .FLRN(FLRN), .OpcodeWB(OpcodeWB),
      .err_sticky(err_sticky), .err_clr(err_clr)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   logic [DATA_W-1:0] m_r0;
   logic [DATA_W-1:0] m_rn [RN_COUNT];
   logic [OPC_W-1:0]  m_opc;
   logic              m_err;
   logic              m_busy;      // a store is outstanding
   logic              m_io;        // outstanding store targets IO
   int                m_age;       // wait cycles already spent on it
   logic [DATA_W-1:0] m_addr, m_mdata, m_iodata;

   wire m_acc = wb_valid && !m_busy;
   wire m_ack = m_io ? io_wr_ack : mem_wr_ack;
   wire m_to  = m_busy && !m_ack && (m_age + 1 == ACK_TIMEOUT);

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_r0 <= '0; m_opc <= '0; m_err <= 1'b0; m_busy <= 1'b0; m_io <= 1'b0;
         m_age <= 0; m_addr <= '0; m_mdata <= '0; m_iodata <= '0;
         for (int i = 0; i < RN_COUNT; i++) m_rn[i] <= '0;
      end else begin
         m_err <= m_to ? 1'b1 : (err_clr ? 1'b0 : m_err);
         if (m_busy) begin
            m_age <= m_age + 1;
            if (m_ack || m_to) m_busy <= 1'b0;
         end else if (wb_valid) begin
            m_opc <= wb_opcode;
            case (wb_dest)
               2'b01: m_r0 <= wb_data;
               2'b10: m_rn[wb_rn_idx] <= wb_data;
               2'b11: begin
                  m_busy <= 1'b1; m_io <= wb_io; m_age <= 0;
                  if (wb_io) m_iodata <= wb_data;
                  else begin m_addr <= wb_addr; m_mdata <= wb_data; end
               end
               default: ;
            endcase
         end
      end
   end

   // Model-vs-DUT comparison every cycle, away from the active edge
   always @(negedge clk) begin
      if (reset_n !== 1'bx) begin
         check("wb_ready",   wb_ready,   !m_busy);
         check("OF_OD1",     OF_OD1,     m_acc ? wb_data : 16'h0);
         check("L_R0",       L_R0,       m_acc && wb_dest == 2'b01);
         check("LRN",        LRN,        m_acc && wb_dest == 2'b10);
         check("FLRN",       FLRN,       m_acc && wb_dest == 2'b10 && wb_rn_idx == rn_sel);
         check("R0_Out",     R0_Out,     m_r0);
         check("RN_Out",     RN_Out,     m_rn[rn_sel]);
         check("OpcodeWB",   OpcodeWB,   m_opc);
         check("err_sticky", err_sticky, m_err);
         check("mem_wr_req", mem_wr_req, m_busy && !m_io);
         check("io_wr_req",  io_wr_req,  m_busy && m_io);
         if (m_busy && !m_io) begin
            check("mem_wr_addr", mem_wr_addr, m_addr);
            check("mem_wr_data", mem_wr_data, m_mdata);
         end
         if (m_busy && m_io) check("io_wr_data", io_wr_data, m_iodata);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc;
      @(posedge clk); #1;
   endtask

   task automatic settle;
      #2;
   endtask

   task automatic present(input logic [1:0] dest, input logic [2:0] idx, input logic io,
                          input logic [15:0] data, input logic [15:0] addr, input logic [2:0] opc);
      wb_valid = 1'b1; wb_dest = dest; wb_rn_idx = idx; wb_io = io;
      wb_data = data; wb_addr = addr; wb_opcode = opc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      #1 reset_n = 1'b0;
      repeat (2) cyc;
      settle;
      check("rst wb_ready", wb_ready, 1);
      check("rst R0_Out", R0_Out, 0);
      check("rst OpcodeWB", OpcodeWB, 0);
      check("rst err", err_sticky, 0);
      check("rst mem_req", mem_wr_req, 0);
      check("rst io_req", io_wr_req, 0);
      reset_n = 1'b1;

      // R0 write with same-cycle forwarding
      cyc; present(2'b01, 3'd0, 1'b0, 16'h00A5, 16'h0, 3'd5);
      settle;
      check("t1 L_R0", L_R0, 1);
      check("t1 OF_OD1", OF_OD1, 16'h00A5);
      cyc; wb_valid = 1'b0;
      settle;
      check("t1 R0_Out", R0_Out, 16'h00A5);
      check("t1 L_R0 off", L_R0, 0);
      check("t1 OpcodeWB", OpcodeWB, 5);

      // Back-to-back RN writes, read port on index 5
      cyc; rn_sel = 3'd5; present(2'b10, 3'd3, 1'b0, 16'h1234, 16'h0, 3'd2);
      settle;
      check("t2 LRN a", LRN, 1);
      check("t2 FLRN a", FLRN, 0);
      cyc; present(2'b10, 3'd5, 1'b0, 16'h5678, 16'h0, 3'd3);
      settle;
      check("t2 LRN b", LRN, 1);
      check("t2 FLRN b", FLRN, 1);
      cyc; wb_valid = 1'b0;
      settle;
      check("t2 RN5", RN_Out, 16'h5678);
      rn_sel = 3'd3; #1;
      check("t2 RN3", RN_Out, 16'h1234);

      // Memory store, ack in third wait cycle; next result held meanwhile
      cyc; mem_wr_ack = 1'b1;            // ack while idle is ignored
      present(2'b11, 3'd0, 1'b0, 16'hBEEF, 16'h0040, 3'd4);
      settle;
      check("t3 acc mem_req", mem_wr_req, 0);
      check("t3 acc L_R0", L_R0, 0);
      cyc; mem_wr_ack = 1'b0;
      present(2'b01, 3'd0, 1'b0, 16'h7777, 16'h0, 3'd1);
      for (int i = 1; i <= 3; i++) begin
         if (i > 1) cyc;
         mem_wr_ack = (i == 3);
         settle;
         check("t3 mem_req", mem_wr_req, 1);
         check("t3 addr", mem_wr_addr, 16'h0040);
         check("t3 data", mem_wr_data, 16'hBEEF);
         check("t3 ready", wb_ready, 0);
         check("t3 hold L_R0", L_R0, 0);
         check("t3 R0 kept", R0_Out, 16'h00A5);
         check("t3 RN3 kept", RN_Out, 16'h1234);
      end
      cyc; mem_wr_ack = 1'b0;
      settle;
      check("t3 req drop", mem_wr_req, 0);
      check("t3 ready back", wb_ready, 1);
      check("t3 held accept", L_R0, 1);
      check("t3 R0 still", R0_Out, 16'h00A5);
      cyc; wb_valid = 1'b0;
      settle;
      check("t3 R0 new", R0_Out, 16'h7777);

      // IO store, no ack: timeout after 15 wait cycles
      cyc; present(2'b11, 3'd0, 1'b1, 16'hCAFE, 16'h0010, 3'd6);
      settle;
      check("t4 acc io_req", io_wr_req, 0);
      cyc; wb_valid = 1'b0;
      for (int i = 1; i <= ACK_TIMEOUT; i++) begin
         if (i > 1) cyc;
         mem_wr_ack = (i == 7);          // wrong channel, ignored
         settle;
         check("t4 io_req", io_wr_req, 1);
         check("t4 no mem_req", mem_wr_req, 0);
         check("t4 io_data", io_wr_data, 16'hCAFE);
      end
      cyc; mem_wr_ack = 1'b0;
      settle;
      check("t4 io_req drop", io_wr_req, 0);
      check("t4 err set", err_sticky, 1);
      check("t4 ready", wb_ready, 1);
      err_clr = 1'b1;
      cyc; err_clr = 1'b0;
      settle;
      check("t4 err clr", err_sticky, 0);

      // IO store with ack exactly in the last wait cycle: no error
      cyc; present(2'b11, 3'd0, 1'b1, 16'h0F0F, 16'h0, 3'd7);
      cyc; wb_valid = 1'b0;
      for (int i = 1; i <= ACK_TIMEOUT; i++) begin
         if (i > 1) cyc;
         io_wr_ack = (i == ACK_TIMEOUT);
         settle;
         check("t4b io_req", io_wr_req, 1);
      end
      cyc; io_wr_ack = 1'b0;
      settle;
      check("t4b io_req drop", io_wr_req, 0);
      check("t4b no err", err_sticky, 0);

      // Timeout coinciding with err_clr: set wins
      cyc; present(2'b11, 3'd0, 1'b1, 16'h4242, 16'h0, 3'd1);
      cyc; wb_valid = 1'b0;
      for (int i = 1; i <= ACK_TIMEOUT; i++) begin
         if (i > 1) cyc;
         err_clr = (i == ACK_TIMEOUT);
         settle;
      end
      cyc; err_clr = 1'b0;
      settle;
      check("t4c set wins", err_sticky, 1);
      err_clr = 1'b1;
      cyc; err_clr = 1'b0;
      settle;
      check("t4c cleared", err_sticky, 0);

      // Reset during MEM_WAIT, then a late ack after release
      cyc; present(2'b11, 3'd0, 1'b0, 16'h1357, 16'h0080, 3'd2);
      cyc; wb_valid = 1'b0;
      settle;
      check("t5 mem_req", mem_wr_req, 1);
      reset_n = 1'b0;
      #1;
      check("t5 req low", mem_wr_req, 0);
      check("t5 addr 0", mem_wr_addr, 0);
      check("t5 data 0", mem_wr_data, 0);
      check("t5 R0 0", R0_Out, 0);
      check("t5 RN 0", RN_Out, 0);
      check("t5 opc 0", OpcodeWB, 0);
      cyc; reset_n = 1'b1; mem_wr_ack = 1'b1;
      settle;
      check("t5 ready", wb_ready, 1);
      check("t5 late ack", mem_wr_req, 0);
      cyc; mem_wr_ack = 1'b0;
      rn_sel = 3'd5; present(2'b10, 3'd5, 1'b0, 16'hABCD, 16'h0, 3'd3);
      settle;
      check("t5 FLRN", FLRN, 1);
      cyc; wb_valid = 1'b0;
      settle;
      check("t5 RN5", RN_Out, 16'hABCD);

      cyc;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
